bcd_scan_mux: RTL

Time-multiplexed scan driver for a common-anode multi-digit 7-segment display. It holds a frame of BCD digits and decimal points, and cycles through the digits one at a time. For each digit it presents the BCD code to the downstream BCD-to-7-segment decoder and drives the matching active-low anode. It sits directly upstream of that decoder and owns digit selection, anti-ghosting blanking, leading-zero suppression and tear-free frame updates.

---
 rtl/bcd_scan_pkg.sv | 35 +++
 rtl/bcd_lzb_mask.sv | 30 +++
 rtl/bcd_scan_mux.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/bcd_scan_pkg.sv
// Shared types, constants and the leading-zero helper for the BCD scan driver.
package bcd_scan_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int MAX_DIGITS = 8;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } slot_state_e;

  // Walks from the most significant digit down; a digit is suppressed while every
  // digit from it upward is zero with no decimal point. Digit 0 always shows.
  function automatic logic [MAX_DIGITS-1:0] lzb_mask(
    input logic [4*MAX_DIGITS-1:0] digits,
    input logic [MAX_DIGITS-1:0]   dp,
    input int                      n,
    input logic                    lzb_en
  );
    logic                  run;
    logic [MAX_DIGITS-1:0] mask;
    run  = 1'b1;
    mask = '0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (i < n) begin
        run     = run & (digits[4*i +: 4] == 4'h0) & ~dp[i];
        mask[i] = run & lzb_en & (i != 0);
      end else begin
        mask[i] = 1'b0;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/bcd_lzb_mask.sv
// Combinational leading-zero suppress mask for the displayed frame.
module bcd_lzb_mask
  import bcd_scan_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] digits,
  input  logic [DIGITS-1:0]   dp,
  input  logic                lzb_en,
  output logic [DIGITS-1:0]   mask
);

  logic [4*MAX_DIGITS-1:0] digits_pad_s;
  logic [MAX_DIGITS-1:0]   dp_pad_s;
  logic [MAX_DIGITS-1:0]   mask_full_s;
  logic                    lzb_unused_s;

  // Pad to the helper's fixed width; upper digits are absent and never block suppression.
  always_comb begin
    digits_pad_s                = '0;
    dp_pad_s                    = '0;
    digits_pad_s[4*DIGITS-1:0]  = digits;
    dp_pad_s[DIGITS-1:0]        = dp;
    mask_full_s                 = lzb_mask(digits_pad_s, dp_pad_s, DIGITS, lzb_en);
  end

  assign mask         = mask_full_s[DIGITS-1:0];
  assign lzb_unused_s = ^mask_full_s;

endmodule

// File: rtl/bcd_scan_mux.sv
// Multiplexed common-anode 7-segment scan driver with anti-ghost blanking,
// leading-zero suppression and frame-synchronous (tear-free) updates.
module bcd_scan_mux
  import bcd_scan_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] digits_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                load,
  input  logic                lzb_en,
  output logic [3:0]          bcd,
  output logic [DIGITS-1:0]   an,
  output logic                dp_n,
  output logic                load_ack
);

  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);
  localparam logic [CW-1:0] LAST_CNT   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  logic [CW-1:0]       slot_cnt_r;
  logic [IW-1:0]       idx_r;
  slot_state_e         state_r, state_nxt_s;
  logic [4*DIGITS-1:0] stg_digits_r, act_digits_r;
  logic [DIGITS-1:0]   stg_dp_r, act_dp_r;
  logic                pending_r;
  logic [DIGITS-1:0]   mask_s;
  logic                boundary_s;
  logic [DIGITS-1:0]   an_nxt_s, an_r;
  logic [3:0]          bcd_nxt_s, bcd_r;
  logic                dp_n_nxt_s, dp_n_r, load_ack_r;

  assign boundary_s = (slot_cnt_r == LAST_CNT) && (idx_r == LAST_IDX);

  bcd_lzb_mask #(.DIGITS(DIGITS)) u_lzb (
    .digits (act_digits_r),
    .dp     (act_dp_r),
    .lzb_en (lzb_en),
    .mask   (mask_s)
  );

  // Slot counter and digit index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt_r <= '0;
      idx_r      <= '0;
    end else if (slot_cnt_r == LAST_CNT) begin
      slot_cnt_r <= '0;
      idx_r      <= (idx_r == LAST_IDX) ? '0 : idx_r + IW'(1);
    end else begin
      slot_cnt_r <= slot_cnt_r + CW'(1);
    end
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= BLANK;
    else        state_r <= state_nxt_s;
  end

  // Slot state transitions, aligned so state tracks slot_cnt < BLANK_CYCLES.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      BLANK:   state_nxt_s = (slot_cnt_r == BLANK_LAST) ? ON : BLANK;
      ON:      state_nxt_s = (slot_cnt_r == LAST_CNT) ? BLANK : ON;
      default: state_nxt_s = BLANK;
    endcase
  end

  // Staging/active frame registers; a boundary-cycle load bypasses staging.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_digits_r <= {DIGITS{BLANK_CODE}};
      stg_dp_r     <= '0;
      act_digits_r <= {DIGITS{BLANK_CODE}};
      act_dp_r     <= '0;
      pending_r    <= 1'b0;
      load_ack_r   <= 1'b0;
    end else begin
      if (load) begin
        stg_digits_r <= digits_in;
        stg_dp_r     <= dp_in;
      end
      if (boundary_s) begin
        if (load) begin
          act_digits_r <= digits_in;
          act_dp_r     <= dp_in;
        end else if (pending_r) begin
          act_digits_r <= stg_digits_r;
          act_dp_r     <= stg_dp_r;
        end
        pending_r  <= 1'b0;
        load_ack_r <= load | pending_r;
      end else begin
        if (load) pending_r <= 1'b1;
        load_ack_r <= 1'b0;
      end
    end
  end

  // Next output values from the current slot.
  always_comb begin
    an_nxt_s   = '1;
    bcd_nxt_s  = BLANK_CODE;
    dp_n_nxt_s = 1'b1;
    if (state_r == ON) begin
      an_nxt_s   = ~(DIGITS'(1) << idx_r);
      bcd_nxt_s  = mask_s[idx_r] ? BLANK_CODE : act_digits_r[{idx_r, 2'b00} +: 4];
      dp_n_nxt_s = ~act_dp_r[idx_r];
    end else begin
      an_nxt_s   = '1;
      bcd_nxt_s  = BLANK_CODE;
      dp_n_nxt_s = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_r   <= '1;
      bcd_r  <= BLANK_CODE;
      dp_n_r <= 1'b1;
    end else begin
      an_r   <= an_nxt_s;
      bcd_r  <= bcd_nxt_s;
      dp_n_r <= dp_n_nxt_s;
    end
  end

  assign an       = an_r;
  assign bcd      = bcd_r;
  assign dp_n     = dp_n_r;
  assign load_ack = load_ack_r;

endmodule
